vxm_stream_engine: RTL

VXM_STREAM_ENGINE -- requirements
Module: vxm_stream_engine

---
 rtl/tsp_pkg.sv | 26 ++
 rtl/vxm_lane_alu.sv | 45 ++++
 rtl/vxm_stream_engine.sv | 96 +++++++++
 3 files changed

// File: rtl/tsp_pkg.sv
// Shared types and defaults for the tensor streaming vector engine.
// Holds the op encoding and the width rule for the lane reduction.
package tsp_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpMul = 3'd2,
    OpMax = 3'd3,
    OpMin = 3'd4,
    OpAnd = 3'd5,
    OpOr  = 3'd6,
    OpXor = 3'd7
  } vxm_op_t;

  localparam int unsigned DEF_NUM_TILES_PER_SLICE = 20;
  localparam int unsigned DEF_MIN_VEC_LENGTH      = 16;
  localparam int unsigned DEF_NUM_VECTORS         = 5;
  localparam int unsigned DEF_NUM_STREAM_ID       = 5;

  // Headroom so a sum of 'tiles' signed w-bit lanes can never overflow.
  function automatic int unsigned reduce_width(input int unsigned tiles, input int unsigned w);
    return w + $clog2(tiles);
  endfunction

endpackage

// File: rtl/vxm_lane_alu.sv
// Combinational single-lane ALU: signed add/sub with optional saturation,
// low-half multiply, signed max/min and bitwise ops.
module vxm_lane_alu
  import tsp_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  vxm_op_t      op,
  input  logic         saturate,
  output logic [W-1:0] result
);

  logic [W:0]   sum_ext;
  logic [W:0]   dif_ext;
  logic [W-1:0] prod;
  logic [W-1:0] smax;
  logic [W-1:0] smin;

  assign sum_ext = {a[W-1], a} + {b[W-1], b};
  assign dif_ext = {a[W-1], a} - {b[W-1], b};
  assign prod    = a * b;
  assign smax    = {1'b0, {(W-1){1'b1}}};
  assign smin    = {1'b1, {(W-1){1'b0}}};

  // Overflow shows as disagreement between the guard bit and the result sign.
  always_comb begin
    result = '0;
    unique case (op)
      OpAdd: result = (saturate && (sum_ext[W] != sum_ext[W-1])) ?
                      (sum_ext[W] ? smin : smax) : sum_ext[W-1:0];
      OpSub: result = (saturate && (dif_ext[W] != dif_ext[W-1])) ?
                      (dif_ext[W] ? smin : smax) : dif_ext[W-1:0];
      OpMul: result = prod;
      OpMax: result = ($signed(a) > $signed(b)) ? a : b;
      OpMin: result = ($signed(a) < $signed(b)) ? a : b;
      OpAnd: result = a & b;
      OpOr:  result = a | b;
      OpXor: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vxm_stream_engine.sv
// Two-stage streaming vector engine: S1 elementwise ALU with lane masking,
// S2 signed lane reduction; valid/ready handshake on both sides.
module vxm_stream_engine
  import tsp_pkg::*;
#(
  parameter int unsigned NUM_TILES_PER_SLICE = DEF_NUM_TILES_PER_SLICE,
  parameter int unsigned MIN_VEC_LENGTH      = DEF_MIN_VEC_LENGTH,
  parameter int unsigned NUM_VECTORS         = DEF_NUM_VECTORS,
  parameter int unsigned NUM_STREAM_ID       = DEF_NUM_STREAM_ID,
  localparam int unsigned RW = reduce_width(NUM_TILES_PER_SLICE, MIN_VEC_LENGTH)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [2:0]                                        op,
  input  logic                                              saturate,
  input  logic [NUM_VECTORS-1:0]                            vector_length,
  input  logic [NUM_STREAM_ID-1:0]                          stream_dest,
  input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] operand1,
  input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] operand2,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] vxm_result,
  output logic signed [RW-1:0]                              reduce_sum,
  output logic [NUM_STREAM_ID-1:0]                          out_stream_id,
  output logic [31:0]                                       beat_count,
  output logic                                              busy
);

  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] alu_res;
  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] lane_res;
  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] s1_res;
  logic [NUM_STREAM_ID-1:0]                           s1_id;
  logic                                               s1_valid;
  logic                                               s2_adv;
  logic signed [RW-1:0]                               sum_d;

  // out_valid is the S2 valid bit; S2 frees up when empty or draining.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign busy     = s1_valid || out_valid;

  for (genvar i = 0; i < NUM_TILES_PER_SLICE; i++) begin : g_lane
    vxm_lane_alu #(
      .W(MIN_VEC_LENGTH)
    ) u_alu (
      .a        (operand1[i]),
      .b        (operand2[i]),
      .op       (vxm_op_t'(op)),
      .saturate (saturate),
      .result   (alu_res[i])
    );
    assign lane_res[i] = (i < int'(vector_length)) ? alu_res[i] : '0;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
      sum_d = sum_d + RW'($signed(s1_res[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_res        <= '0;
      s1_id         <= '0;
      out_valid     <= 1'b0;
      vxm_result    <= '0;
      reduce_sum    <= '0;
      out_stream_id <= '0;
      beat_count    <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_res <= lane_res;
          s1_id  <= stream_dest;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          vxm_result    <= s1_res;
          reduce_sum    <= sum_d;
          out_stream_id <= s1_id;
        end
      end
      if (out_valid && out_ready) begin
        beat_count <= beat_count + 32'd1;
      end
    end
  end

endmodule
